obi_rr_mux: RTL and testbench

//  Shares one OBI subordinate port, e.g. the bus watched by the bus error unit, between NumReq OBI managers.

---
 rtl/obi_rr_mux_pkg.sv | 40 ++++
 rtl/obi_rr_mux_idx_fifo.sv | 66 ++++++
 rtl/obi_rr_mux.sv | 152 +++++++++++++++
 tb/tb_obi_rr_mux.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_rr_mux_pkg.sv
// Shared types and the round-robin pick helper for obi_rr_mux.
package obi_rr_mux_pkg;

    typedef enum logic {
        ARB,
        HOLD
    } arb_state_e;

    // Widest request vector rr_pick can scan; obi_rr_mux needs NumReq <= RrMaxReq.
    localparam int unsigned RrMaxReq = 32;
    localparam int unsigned RrIdxW   = 5;

    typedef logic [RrIdxW-1:0] rr_idx_t;
    typedef logic [RrIdxW:0]   rr_num_t;

    // First set bit of req[num-1:0], scanning upward from ptr with wrap at num.
    function automatic rr_idx_t rr_pick(
        input  logic [RrMaxReq-1:0] req,
        input  rr_idx_t             ptr,
        input  rr_num_t             num,
        output logic                found
    );
        rr_num_t pos;
        rr_idx_t pick;
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 0; i < RrMaxReq; i++) begin
            pos = {1'b0, ptr} + rr_num_t'(i);
            if (pos >= num) begin
                pos = pos - num;
            end
            if (!found && (rr_num_t'(i) < num) && req[pos[RrIdxW-1:0]]) begin
                found = 1'b1;
                pick  = pos[RrIdxW-1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/obi_rr_mux_idx_fifo.sv
// In-order FIFO of small indices with occupancy flags; no bus knowledge.
module obi_rr_mux_idx_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    typedef logic [PtrW-1:0] ptr_t;

    logic [Width-1:0] mem [Depth];
    ptr_t             wr_q;
    ptr_t             rd_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push;
    logic             do_pop;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(Depth - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    assign full    = (cnt_q == CntW'(Depth));
    assign empty   = (cnt_q == '0);
    assign head    = mem[rd_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage array, written at the tail.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_q] <= wdata;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= ptr_inc(wr_q);
            end
            if (do_pop) begin
                rd_q <= ptr_inc(rd_q);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + CntW'(1);
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/obi_rr_mux.sv
// Round-robin mux of NumReq OBI managers onto one OBI subordinate port.
// Optional per-manager error counters: define OBI_RR_MUX_ERR_CNT_EN.
module obi_rr_mux
    import obi_rr_mux_pkg::*;
#(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned ErrBits        = 1,
    parameter int unsigned NumOutstanding = 2,
    parameter int unsigned ErrCntWidth    = 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumReq-1:0]                     m_req_i,
    output logic [NumReq-1:0]                     m_gnt_o,
    input  logic [NumReq-1:0][AddrWidth-1:0]      m_addr_i,
    input  logic [NumReq-1:0]                     m_we_i,
    input  logic [NumReq-1:0][DataWidth/8-1:0]    m_be_i,
    input  logic [NumReq-1:0][DataWidth-1:0]      m_wdata_i,
    output logic [NumReq-1:0]                     m_rvalid_o,
    output logic [DataWidth-1:0]                  m_rdata_o,
    output logic [ErrBits-1:0]                    m_err_o,
    output logic                                  s_req_o,
    input  logic                                  s_gnt_i,
    output logic [AddrWidth-1:0]                  s_addr_o,
    output logic                                  s_we_o,
    output logic [DataWidth/8-1:0]                s_be_o,
    output logic [DataWidth-1:0]                  s_wdata_o,
    input  logic                                  s_rvalid_i,
    input  logic [DataWidth-1:0]                  s_rdata_i,
    input  logic [ErrBits-1:0]                    s_err_i,
    output logic                                  unexp_rsp_o,
    output logic [NumReq-1:0][ErrCntWidth-1:0]    err_cnt_o
);

    typedef logic [$clog2(NumReq)-1:0] idx_t;

    arb_state_e            state_q;
    arb_state_e            state_d;
    idx_t                  sel_q;
    idx_t                  rr_q;
    idx_t                  win_idx;
    idx_t                  sel;
    idx_t                  fifo_head;
    logic                  win_found;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic [RrMaxReq-1:0]   req_ext;

    // Round-robin winner among current requests, starting at the rr pointer.
    always_comb begin
        req_ext             = '0;
        req_ext[NumReq-1:0] = m_req_i;
        win_found           = 1'b0;
        win_idx             = idx_t'(rr_pick(req_ext, rr_idx_t'(rr_q), rr_num_t'(NumReq), win_found));
    end

    // FSM outputs: selected manager and the gated subordinate request.
    always_comb begin
        sel     = win_idx;
        s_req_o = win_found & ~fifo_full;
        if (state_q == HOLD) begin
            sel     = sel_q;
            s_req_o = m_req_i[sel_q] & ~fifo_full;
        end
    end

    // FSM next state: hold a selection from a stalled request until it is granted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:     if (s_req_o && !s_gnt_i) state_d = HOLD;
            HOLD:    if (s_req_o && s_gnt_i)  state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    // FSM state, held selection and rr pointer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ARB;
            sel_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ARB && s_req_o && !s_gnt_i) begin
                sel_q <= win_idx;
            end
            if (push) begin
                rr_q <= (sel == idx_t'(NumReq - 1)) ? '0 : sel + idx_t'(1);
            end
        end
    end

    assign push = s_req_o & s_gnt_i;
    assign pop  = s_rvalid_i & ~fifo_empty;

    assign s_addr_o    = m_addr_i[sel];
    assign s_we_o      = m_we_i[sel];
    assign s_be_o      = m_be_i[sel];
    assign s_wdata_o   = m_wdata_i[sel];
    assign m_rdata_o   = s_rdata_i;
    assign m_err_o     = s_err_i;
    assign unexp_rsp_o = s_rvalid_i & fifo_empty;

    // One-hot grant to the selected manager and response routing to the FIFO head.
    always_comb begin
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        if (push) begin
            m_gnt_o[sel] = 1'b1;
        end
        if (pop) begin
            m_rvalid_o[fifo_head] = 1'b1;
        end
    end

    obi_rr_mux_idx_fifo #(
        .Depth (NumOutstanding),
        .Width ($clog2(NumReq))
    ) u_idx_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .wdata (sel),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef OBI_RR_MUX_ERR_CNT_EN
    logic [NumReq-1:0][ErrCntWidth-1:0] err_cnt_q;

    // Saturating error count for the manager that receives each routed error response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_q <= '0;
        end else if (pop && (|s_err_i) && (err_cnt_q[fifo_head] != '1)) begin
            err_cnt_q[fifo_head] <= err_cnt_q[fifo_head] + ErrCntWidth'(1);
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_obi_rr_mux.sv
// Self-checking bench for obi_rr_mux (NumReq=4, NumOutstanding=2, ErrCntWidth=2).
module tb_obi_rr_mux;

    localparam int N    = 4;
    localparam int NOUT = 2;
    localparam int ECW  = 2;

    logic                 clk_i;
    logic                 rst_i;
    logic [N-1:0]         m_req_i;
    logic [N-1:0]         m_gnt_o;
    logic [N-1:0][31:0]   m_addr_i;
    logic [N-1:0]         m_we_i;
    logic [N-1:0][3:0]    m_be_i;
    logic [N-1:0][31:0]   m_wdata_i;
    logic [N-1:0]         m_rvalid_o;
    logic [31:0]          m_rdata_o;
    logic [0:0]           m_err_o;
    logic                 s_req_o;
    logic                 s_gnt_i;
    logic [31:0]          s_addr_o;
    logic                 s_we_o;
    logic [3:0]           s_be_o;
    logic [31:0]          s_wdata_o;
    logic                 s_rvalid_i;
    logic [31:0]          s_rdata_i;
    logic [0:0]           s_err_i;
    logic                 unexp_rsp_o;
    logic [N-1:0][ECW-1:0] err_cnt_o;

    obi_rr_mux #(
        .NumReq         (N),
        .AddrWidth      (32),
        .DataWidth      (32),
        .ErrBits        (1),
        .NumOutstanding (NOUT),
        .ErrCntWidth    (ECW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .m_req_i     (m_req_i),
        .m_gnt_o     (m_gnt_o),
        .m_addr_i    (m_addr_i),
        .m_we_i      (m_we_i),
        .m_be_i      (m_be_i),
        .m_wdata_i   (m_wdata_i),
        .m_rvalid_o  (m_rvalid_o),
        .m_rdata_o   (m_rdata_o),
        .m_err_o     (m_err_o),
        .s_req_o     (s_req_o),
        .s_gnt_i     (s_gnt_i),
        .s_addr_o    (s_addr_o),
        .s_we_o      (s_we_o),
        .s_be_o      (s_be_o),
        .s_wdata_o   (s_wdata_o),
        .s_rvalid_i  (s_rvalid_i),
        .s_rdata_i   (s_rdata_i),
        .s_err_i     (s_err_i),
        .unexp_rsp_o (unexp_rsp_o),
        .err_cnt_o   (err_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks;
    int failures;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] req, input logic gnt, input logic rv, input logic err);
        m_req_i    = req;
        s_gnt_i    = gnt;
        s_rvalid_i = rv;
        s_err_i    = err;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic         gnt;
        logic         rv;
        logic [N-1:0] exp_gnt;
        logic         exp_sreq;
        logic [N-1:0] exp_rv;
        logic         exp_unexp;
    } vec_t;

    vec_t vecs[8];

    // Reference model state: outstanding managers in issue order, rr pointer, held manager.
    int   q[$];
    int   ptr;
    int   locked;
    int   ecnt[N];
    int   cand;
    int   head;
    bit   full;
    bit   exp_sreq;
    bit   hs;
    logic [N-1:0]          exp_gnt;
    logic [N-1:0]          exp_rv;
    logic [N-1:0][ECW-1:0] exp_ecnt;
    int   exp_e[6];

    initial begin
        checks   = 0;
        failures = 0;
        rst_i    = 1'b1;
        drive('0, 1'b0, 1'b0, 1'b0);
        s_rdata_i = 32'h0;
        for (int k = 0; k < N; k++) begin
            m_addr_i[k]  = 32'hA000_0000 + 32'(k * 16);
            m_we_i[k]    = k[0];
            m_be_i[k]    = 4'hF;
            m_wdata_i[k] = 32'h5500_0000 + 32'(k);
        end

        //                req      gnt   rv    exp_gnt  sreq  exp_rv   unexp
        vecs[0] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};
        vecs[1] = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 4'b0000, 1'b0};
        vecs[2] = '{4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 4'b0001, 1'b0};
        vecs[3] = '{4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1, 4'b0010, 1'b0};
        vecs[4] = '{4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, 4'b0100, 1'b0};
        vecs[5] = '{4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 4'b1000, 1'b0};
        vecs[6] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0001, 1'b0};
        vecs[7] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1};

`ifdef OBI_RR_MUX_ERR_CNT_EN
        exp_e = '{0, 1, 2, 3, 3, 3};
`else
        exp_e = '{0, 0, 0, 0, 0, 0};
`endif

        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #2;
        chk("reset_err_cnt", 64'(err_cnt_o), 64'h0);

        // Round-robin rotation with all managers requesting, then empty-FIFO response.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].req, vecs[i].gnt, vecs[i].rv, 1'b0);
            #2;
            chk("vec_gnt", 64'(m_gnt_o), 64'(vecs[i].exp_gnt));
            chk("vec_sreq", 64'(s_req_o), 64'(vecs[i].exp_sreq));
            chk("vec_rvalid", 64'(m_rvalid_o), 64'(vecs[i].exp_rv));
            chk("vec_unexp", 64'(unexp_rsp_o), 64'(vecs[i].exp_unexp));
            tick();
        end
        drive('0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("unexp_one_cycle", 64'(unexp_rsp_o), 64'h0);
        tick();

        // Hold: pointer is 1; grant mgr2 to move it to 3, drain, then stall mgr2.
        drive(4'b0100, 1'b1, 1'b0, 1'b0);
        #2;
        chk("hold_setup_gnt", 64'(m_gnt_o), 64'b0100);
        tick();
        drive(4'b0000, 1'b0, 1'b1, 1'b0);
        #2;
        chk("hold_setup_rv", 64'(m_rvalid_o), 64'b0100);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(4'b0100, 1'b0, 1'b0, 1'b0);
            #2;
            chk("hold_sreq", 64'(s_req_o), 64'h1);
            chk("hold_addr", 64'(s_addr_o), 64'(m_addr_i[2]));
            chk("hold_nogrant", 64'(m_gnt_o), 64'h0);
            tick();
        end
        drive(4'b0101, 1'b0, 1'b0, 1'b0);
        #2;
        chk("hold_addr_mgr0_up", 64'(s_addr_o), 64'(m_addr_i[2]));
        tick();
        drive(4'b0101, 1'b1, 1'b0, 1'b0);
        #2;
        chk("hold_gnt", 64'(m_gnt_o), 64'b0100);
        chk("hold_gnt_addr", 64'(s_addr_o), 64'(m_addr_i[2]));
        tick();
        drive(4'b0001, 1'b0, 1'b1, 1'b0);
        #2;
        chk("hold_next_addr", 64'(s_addr_o), 64'(m_addr_i[0]));
        chk("hold_rv", 64'(m_rvalid_o), 64'b0100);
        tick();
        drive(4'b0001, 1'b1, 1'b0, 1'b0);
        #2;
        chk("hold_gnt0", 64'(m_gnt_o), 64'b0001);
        tick();
        drive(4'b0000, 1'b0, 1'b1, 1'b0);
        #2;
        chk("hold_rv0", 64'(m_rvalid_o), 64'b0001);
        tick();

        // Outstanding limit: grant mgr1 and mgr3, mgr0 waits for the first response.
        drive(4'b0010, 1'b1, 1'b0, 1'b0);
        #2;
        chk("out_gnt1", 64'(m_gnt_o), 64'b0010);
        tick();
        drive(4'b1000, 1'b1, 1'b0, 1'b0);
        #2;
        chk("out_gnt3", 64'(m_gnt_o), 64'b1000);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(4'b0001, 1'b1, 1'b0, 1'b0);
            #2;
            chk("out_full_sreq", 64'(s_req_o), 64'h0);
            chk("out_full_gnt", 64'(m_gnt_o), 64'h0);
            tick();
        end
        drive(4'b0001, 1'b1, 1'b1, 1'b0);
        #2;
        chk("out_rv1", 64'(m_rvalid_o), 64'b0010);
        chk("out_full_pop_sreq", 64'(s_req_o), 64'h0);
        tick();
        drive(4'b0001, 1'b1, 1'b1, 1'b0);
        #2;
        chk("out_gnt0", 64'(m_gnt_o), 64'b0001);
        chk("out_rv3", 64'(m_rvalid_o), 64'b1000);
        tick();
        drive(4'b0000, 1'b0, 1'b1, 1'b0);
        #2;
        chk("out_rv0", 64'(m_rvalid_o), 64'b0001);
        tick();

        // Error responses to mgr0: first clean, then five errors.
        for (int i = 0; i < 6; i++) begin
            drive(4'b0001, 1'b1, 1'b0, 1'b0);
            #2;
            chk("err_gnt0", 64'(m_gnt_o), 64'b0001);
            tick();
            drive(4'b0000, 1'b0, 1'b1, (i != 0));
            #2;
            chk("err_rv0", 64'(m_rvalid_o), 64'b0001);
            chk("err_bcast", 64'(m_err_o), 64'(i != 0));
            tick();
            drive(4'b0000, 1'b0, 1'b0, 1'b0);
            chk("err_cnt", 64'(err_cnt_o), 64'(exp_e[i]));
        end

        // Async reset with two outstanding entries.
        drive(4'b0010, 1'b1, 1'b0, 1'b0);
        #2;
        chk("rst_gnt1", 64'(m_gnt_o), 64'b0010);
        tick();
        drive(4'b0100, 1'b1, 1'b0, 1'b0);
        #2;
        chk("rst_gnt2", 64'(m_gnt_o), 64'b0100);
        tick();
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        #2;
        rst_i = 1'b1;
        #2;
        rst_i = 1'b0;
        chk("rst_err_cnt", 64'(err_cnt_o), 64'h0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(4'b0000, 1'b0, 1'b1, 1'b0);
            #2;
            chk("rst_unexp", 64'(unexp_rsp_o), 64'h1);
            chk("rst_no_rv", 64'(m_rvalid_o), 64'h0);
            tick();
        end
        drive(4'b0000, 1'b0, 1'b0, 1'b0);

        // Randomised traffic against the queue model.
        q.delete();
        ptr    = 0;
        locked = -1;
        for (int k = 0; k < N; k++) ecnt[k] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < N; k++) begin
                if (!m_req_i[k] && $urandom_range(0, 2) == 0) begin
                    m_req_i[k]   = 1'b1;
                    m_addr_i[k]  = $urandom;
                    m_we_i[k]    = 1'($urandom);
                    m_be_i[k]    = 4'($urandom);
                    m_wdata_i[k] = $urandom;
                end
            end
            s_gnt_i    = 1'($urandom);
            s_rvalid_i = ($urandom_range(0, 3) != 0);
            s_rdata_i  = $urandom;
            s_err_i    = 1'($urandom);
            #2;

            full = (q.size() >= NOUT);
            cand = -1;
            if (locked >= 0) begin
                if (m_req_i[locked]) cand = locked;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (cand < 0 && m_req_i[(ptr + i) % N]) cand = (ptr + i) % N;
                end
            end
            exp_sreq = (cand >= 0) && !full;
            hs       = exp_sreq && s_gnt_i;
            exp_gnt  = hs ? N'(1 << cand) : '0;
            head     = (s_rvalid_i && q.size() > 0) ? q[0] : -1;
            exp_rv   = (head >= 0) ? N'(1 << head) : '0;
            for (int k = 0; k < N; k++) begin
`ifdef OBI_RR_MUX_ERR_CNT_EN
                exp_ecnt[k] = ECW'(ecnt[k]);
`else
                exp_ecnt[k] = '0;
`endif
            end

            chk("rnd_sreq", 64'(s_req_o), 64'(exp_sreq));
            chk("rnd_gnt", 64'(m_gnt_o), 64'(exp_gnt));
            chk("rnd_rvalid", 64'(m_rvalid_o), 64'(exp_rv));
            chk("rnd_unexp", 64'(unexp_rsp_o), 64'(s_rvalid_i && q.size() == 0));
            chk("rnd_err_cnt", 64'(err_cnt_o), 64'(exp_ecnt));
            if (exp_sreq) begin
                chk("rnd_addr", 64'(s_addr_o), 64'(m_addr_i[cand]));
                chk("rnd_wdata", 64'({s_we_o, s_be_o, s_wdata_o}),
                    64'({m_we_i[cand], m_be_i[cand], m_wdata_i[cand]}));
            end
            if (head >= 0) begin
                chk("rnd_rdata", 64'({m_err_o, m_rdata_o}), 64'({s_err_i, s_rdata_i}));
            end

            @(posedge clk_i);
            #1;
            if (head >= 0) begin
                void'(q.pop_front());
                if (s_err_i[0] && ecnt[head] < (1 << ECW) - 1) ecnt[head]++;
            end
            if (hs) begin
                q.push_back(cand);
                ptr          = (cand + 1) % N;
                locked       = -1;
                m_req_i[cand] = 1'b0;
            end else if (exp_sreq && locked < 0) begin
                locked = cand;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
